multibyte_add_seq: RTL and testbench
====================================

# multibyte_add_seq

Sequencer that performs NUM_BYTES-wide addition or subtraction by driving one shared 8-bit carry-lookahead adder one byte per cycle, least-significant byte first, with the carry registered between bytes. It sits between the register-file/operand logic and the result bus. It trades latency for area: one 8-bit adder serves any operand width. Operands are accepted and results returned through valid/ready handshakes.

## Interface
- NUM_BYTES, 4, operand width in bytes; legal range 2..16
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  operand set offered
- in_ready  out  1  block can accept operands (high only in IDLE)
- op_a  in  8*NUM_BYTES  first operand
- op_b  in  8*NUM_BYTES  second operand
- carry_in  in  1  carry into byte 0 (borrow-in when sub=1, see Operation)
- sub  in  1  0 = A+B, 1 = A−B
- out_valid  out  1  result held and valid
- out_ready  in  1  consumer takes result
- result  out  8*NUM_BYTES  sum or difference
- carry_out  out  1  carry out of the top byte; for sub, 1 = no borrow
- overflow  out  1  signed two's-complement overflow
- busy  out  1  high in RUN or DONE

## Operation
- FSM states: IDLE, RUN, DONE. Encoding is a shared enum.
- IDLE: in_ready=1. On in_valid&in_ready:
  - latch op_a into A_reg.
  - latch op_b, or ~op_b when sub=1, into B_reg.
  - carry_reg ← carry_in ^ sub.
  - byte_idx ← 0; sub_reg ← sub; go to RUN.
- RUN, each cycle:
  - Adder inputs: A_reg byte byte_idx, B_reg byte byte_idx, carry_reg.
  - Write the adder sum into result byte byte_idx; carry_reg ← adder carry out.
  - On byte_idx = NUM_BYTES−1:
    - carry_out ← adder carry out.
    - overflow ← (adder carry out) XOR (carry into bit 7), where carry into bit 7 = A7 ^ B7' ^ S7.
    - go to DONE.
  - Otherwise byte_idx ← byte_idx + 1.
- DONE: out_valid=1; result, carry_out and overflow are stable. On out_ready, go to IDLE.
- The handshake is a strict alternation: a new request is accepted only in IDLE, so at most one operation is in flight. in_valid during RUN or DONE is ignored (in_ready=0), and the offer must be held by the source.
- carry_in with sub=1 is a borrow-in: carry_in=0 computes A−B; carry_in=1 computes A−B−1.
- byte_idx counter width: $clog2(NUM_BYTES). It never wraps, because the terminal count forces the DONE transition.

## Timing
- Reset (async assert, sync deassert externally):
  - state=IDLE, in_ready=1, out_valid=0, busy=0.
  - result=0, carry_out=0, overflow=0, byte_idx=0, carry_reg=0.
- Latency: acceptance in cycle T gives RUN in cycles T+1..T+NUM_BYTES, and out_valid asserts in cycle T+NUM_BYTES+1.
- Throughput: one operation per NUM_BYTES+2 cycles when out_ready is held high. DONE exits on the same cycle out_ready is sampled, and in_ready is high the next cycle.
- Result bytes update only in RUN. Bytes not yet computed hold the previous operation's value until overwritten; consumers sample only while out_valid=1.
- The adder path is purely combinational in one cycle. No adder output is used outside RUN.
- Reset mid-RUN or mid-DONE aborts the operation with no output. The next acceptance is possible on the first clock after deassertion.
- out_ready while not in DONE has no effect.

## Structure
- Shared package multibyte_add_pkg holds:
  - the state enum (IDLE/RUN/DONE);
  - localparam BYTE_W = 8;
  - a function computing the signed-overflow bit from A7, B7', S7 and cout.
- One sub-module instance: the existing 8-bit carry-lookahead adder _8BitCLA, used unmodified.
- Its clk/rst pins are tied to this block's clk/rst. They are unused by its combinational logic, so no polarity conflict arises.
- Byte select uses indexed part-select on A_reg/B_reg/result; no separate mux module.

## Test plan
- NUM_BYTES=4, A=0x000000FF, B=0x00000001, sub=0, cin=0 → result 0x00000100, carry_out 0, overflow 0. out_valid asserts exactly 5 cycles after acceptance.
- A=0xFFFFFFFF, B=0x00000001, sub=0 → result 0x00000000, carry_out 1, overflow 0. A=0x7FFFFFFF, B=1 → result 0x80000000, overflow 1.
- Subtraction, both borrow cases:
  - A=0x00000005, B=0x00000007, sub=1, cin=0 → result 0xFFFFFFFE, carry_out 0 (borrow).
  - Same operands with cin=1 → result 0xFFFFFFFD.
- Backpressure:
  - Hold out_ready=0 for 10 cycles in DONE → outputs stable, in_ready=0, a new in_valid is ignored.
  - Release out_ready → IDLE next cycle, then accept the pending operands.
- Reset and randomised checks:
  - Assert rst at RUN byte 2 → all outputs return to their reset values immediately; a fresh operation afterwards completes correctly.
  - Run 1000 random operand/sub/cin sets per NUM_BYTES ∈ {2,4,16}, compared against a reference model of the wide add.

Source files
------------

// File: rtl/multibyte_add_pkg.sv
// Shared definitions for the multi-byte add/sub sequencer.
//   state_t    : sequencer FSM encoding (IDLE/RUN/DONE)
//   BYTE_W     : width of the shared adder slice
//   signed_ovf : two's-complement overflow from the top byte's MSB terms
package multibyte_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int BYTE_W = 8;

  // Carry into bit 7 is recovered as a7 ^ b7 ^ s7; overflow is that carry
  // disagreeing with the carry leaving bit 7.
  function automatic logic signed_ovf(input logic a7, input logic b7,
                                      input logic s7, input logic cout);
    return cout ^ (a7 ^ b7 ^ s7);
  endfunction

endpackage

// File: rtl/_8BitCLA.sv
// 8-bit carry-lookahead adder (combinational).
//   clk, rst : present for pin compatibility only; not used
//   a, b     : addends
//   cin      : carry in
//   sum      : a + b + cin (low 8 bits)
//   cout     : carry out of bit 7
module _8BitCLA (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [7:0] p, g;
  logic [8:0] c;
  logic       unused_clk_rst;

  assign unused_clk_rst = clk ^ rst;

  assign p = a ^ b;
  assign g = a & b;

  // Each carry is built directly from generate/propagate terms and cin,
  // so no carry depends on a lower computed carry.
  function automatic logic la_carry(input int n, input logic [7:0] gg,
                                    input logic [7:0] pp, input logic c0);
    logic acc, run;
    acc = 1'b0;
    run = 1'b1;
    for (int j = n - 1; j >= 0; j--) begin
      acc = acc | (run & gg[j]);
      run = run & pp[j];
    end
    return acc | (run & c0);
  endfunction

  for (genvar i = 0; i <= 8; i++) begin : g_carry
    assign c[i] = la_carry(i, g, p, cin);
  end

  assign sum  = p ^ c[7:0];
  assign cout = c[8];

endmodule

// File: rtl/multibyte_add_seq.sv
// Multi-byte add/subtract sequencer. One shared 8-bit CLA processes one
// byte per cycle, LSB first, with the carry registered between bytes.
//   clk, rst (async, active low)
//   in_valid/in_ready  : operand handshake (ready only in IDLE)
//   op_a, op_b         : operands, 8*NUM_BYTES wide
//   carry_in, sub      : carry/borrow-in and add(0)/sub(1) select
//   out_valid/out_ready: result handshake (valid only in DONE)
//   result, carry_out, overflow : held while out_valid
//   busy               : RUN or DONE
// NUM_BYTES legal range is 2..16.
module multibyte_add_seq
  import multibyte_add_pkg::*;
#(
  parameter int NUM_BYTES = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [BYTE_W*NUM_BYTES-1:0] op_a,
  input  logic [BYTE_W*NUM_BYTES-1:0] op_b,
  input  logic                        carry_in,
  input  logic                        sub,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [BYTE_W*NUM_BYTES-1:0] result,
  output logic                        carry_out,
  output logic                        overflow,
  output logic                        busy
);

  localparam int W     = BYTE_W * NUM_BYTES;
  localparam int IDX_W = $clog2(NUM_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  state_t           state;
  logic [W-1:0]     a_reg, b_reg;
  logic             carry_reg;
  logic [IDX_W-1:0] byte_idx;
  logic [IDX_W+2:0] bit_base;
  logic [7:0]       a_byte, b_byte, sum_byte;
  logic             add_cout;

  // byte_idx * 8 without a multiplier
  assign bit_base = {byte_idx, 3'b000};
  assign a_byte   = a_reg[bit_base +: BYTE_W];
  assign b_byte   = b_reg[bit_base +: BYTE_W];

  _8BitCLA u_cla (
    .clk  (clk),
    .rst  (rst),
    .a    (a_byte),
    .b    (b_byte),
    .cin  (carry_reg),
    .sum  (sum_byte),
    .cout (add_cout)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // Subtraction is A + ~B + 1 with the borrow-in folded into the initial
  // carry, so B is inverted at capture and the adder never needs to know
  // the operation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      byte_idx  <= '0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= op_a;
            b_reg     <= sub ? ~op_b : op_b;
            carry_reg <= carry_in ^ sub;
            byte_idx  <= '0;
            state     <= RUN;
          end
        end
        RUN: begin
          result[bit_base +: BYTE_W] <= sum_byte;
          carry_reg                  <= add_cout;
          if (byte_idx == LAST_IDX) begin
            carry_out <= add_cout;
            overflow  <= signed_ovf(a_byte[7], b_byte[7], sum_byte[7], add_cout);
            state     <= DONE;
          end else begin
            byte_idx <= byte_idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multibyte_add_seq.sv
// Directed and random checks of multibyte_add_seq at NUM_BYTES = 2, 4, 16.
module tb_multibyte_add_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] op_a, op_b;
  logic         carry_in, sub;
  logic         in_valid4, out_ready4, in_valid_x, out_ready_x;

  logic         in_ready4, out_valid4, co4, ov4, busy4;
  logic [31:0]  result4;
  logic         in_ready2, out_valid2, co2, ov2, busy2;
  logic [15:0]  result2;
  logic         in_ready16, out_valid16, co16, ov16, busy16;
  logic [127:0] result16;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  multibyte_add_seq #(.NUM_BYTES(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .op_a(op_a[31:0]), .op_b(op_b[31:0]), .carry_in(carry_in), .sub(sub),
    .out_valid(out_valid4), .out_ready(out_ready4), .result(result4),
    .carry_out(co4), .overflow(ov4), .busy(busy4)
  );

  multibyte_add_seq #(.NUM_BYTES(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid_x), .in_ready(in_ready2),
    .op_a(op_a[15:0]), .op_b(op_b[15:0]), .carry_in(carry_in), .sub(sub),
    .out_valid(out_valid2), .out_ready(out_ready_x), .result(result2),
    .carry_out(co2), .overflow(ov2), .busy(busy2)
  );

  multibyte_add_seq #(.NUM_BYTES(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid_x), .in_ready(in_ready16),
    .op_a(op_a), .op_b(op_b), .carry_in(carry_in), .sub(sub),
    .out_valid(out_valid16), .out_ready(out_ready_x), .result(result16),
    .carry_out(co16), .overflow(ov16), .busy(busy16)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Wide reference: A + B + cin, or A - B - cin as A + ~B + !cin.
  function automatic void model(input int n, input logic [127:0] a,
                                input logic [127:0] b, input logic cin,
                                input logic s, output logic [127:0] r,
                                output logic co, output logic ov);
    logic [128:0] mask, aa, bb, sm;
    int w;
    w    = 8 * n;
    mask = (129'd1 << w) - 129'd1;
    aa   = {1'b0, a} & mask;
    bb   = {1'b0, (s ? ~b : b)} & mask;
    sm   = aa + bb + {128'd0, cin ^ s};
    r    = sm[127:0] & mask[127:0];
    co   = sm[w];
    ov   = (aa[w-1] == bb[w-1]) && (sm[w-1] != aa[w-1]);
  endfunction

  // Offer one operation to dut4 and wait for out_valid; lat counts clock
  // edges from the accepting edge to the edge that enters DONE.
  task automatic run4(input logic [31:0] a, input logic [31:0] b,
                      input logic cin, input logic s,
                      output int lat, output logic to);
    int w;
    @(negedge clk);
    op_a = {96'd0, a}; op_b = {96'd0, b}; carry_in = cin; sub = s;
    out_ready4 = 1'b0; in_valid4 = 1'b1;
    w = 0;
    while (!in_ready4 && w < 50) begin @(negedge clk); w++; end
    @(posedge clk); #1 in_valid4 = 1'b0;
    lat = 0;
    while (!out_valid4 && lat < 100) begin @(posedge clk); #1 lat++; end
    to = !out_valid4;
  endtask

  task automatic release4();
    @(negedge clk); out_ready4 = 1'b1;
    @(posedge clk); #1 out_ready4 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    in_valid4 = 0; out_ready4 = 0; in_valid_x = 0; out_ready_x = 0;
    op_a = '0; op_b = '0; carry_in = 0; sub = 0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({in_ready4, out_valid4, busy4} !== 3'b100) begin
      n_fail++; $display("FAIL reset_flags got %b exp 100", {in_ready4, out_valid4, busy4});
    end
    n_checks++;
    if ({result4, co4, ov4} !== 34'd0) begin
      n_fail++; $display("FAIL reset_outputs got %h/%b/%b exp 0/0/0", result4, co4, ov4);
    end
    n_checks++;
    if ({in_ready16, out_valid16, busy16, result16} !== {3'b100, 128'd0}) begin
      n_fail++; $display("FAIL reset_dut16 got %b%b%b %h exp 100 0", in_ready16, out_valid16, busy16, result16);
    end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_add();
    int lat; logic to;
    run4(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, lat, to);
    n_checks++;
    if (to || lat != 4) begin
      n_fail++; $display("FAIL add_latency got %0d edges (timeout %b) exp 4", lat, to);
    end
    n_checks++;
    if ({result4, co4, ov4} !== {32'h0000_0100, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL add_ff_1 got %h/%b/%b exp 00000100/0/0", result4, co4, ov4);
    end
    n_checks++;
    if ({in_ready4, busy4} !== 2'b01) begin
      n_fail++; $display("FAIL done_flags got ready=%b busy=%b exp 0/1", in_ready4, busy4);
    end
    release4();
  endtask

  task automatic test_carry();
    int lat; logic to;
    run4(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, lat, to);
    n_checks++;
    if (to || {result4, co4, ov4} !== {32'h0, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL add_wrap got %h/%b/%b exp 00000000/1/0", result4, co4, ov4);
    end
    release4();
    run4(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, lat, to);
    n_checks++;
    if (to || {result4, co4, ov4} !== {32'h8000_0000, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL add_ovf got %h/%b/%b exp 80000000/0/1", result4, co4, ov4);
    end
    release4();
  endtask

  task automatic test_sub();
    int lat; logic to;
    run4(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, lat, to);
    n_checks++;
    if (to || {result4, co4, ov4} !== {32'hFFFF_FFFE, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL sub_borrow got %h/%b/%b exp FFFFFFFE/0/0", result4, co4, ov4);
    end
    release4();
    run4(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, lat, to);
    n_checks++;
    if (to || {result4, co4, ov4} !== {32'hFFFF_FFFD, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL sub_borrow_in got %h/%b/%b exp FFFFFFFD/0/0", result4, co4, ov4);
    end
    release4();
    run4(32'h0000_0009, 32'h0000_0002, 1'b0, 1'b1, lat, to);
    n_checks++;
    if (to || {result4, co4, ov4} !== {32'h0000_0007, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL sub_no_borrow got %h/%b/%b exp 00000007/1/0", result4, co4, ov4);
    end
    release4();
  endtask

  task automatic test_backpressure();
    int lat; logic to; int k;
    run4(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0, lat, to);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      op_a = 128'h1234_5678; op_b = 128'h1111_1111; carry_in = 0; sub = 0;
      in_valid4 = 1'b1;
      n_checks++;
      if ({out_valid4, in_ready4, result4} !== {1'b1, 1'b0, 32'h0000_0030}) begin
        n_fail++; $display("FAIL bp_hold cyc %0d got valid=%b ready=%b %h exp 1/0/00000030",
                           i, out_valid4, in_ready4, result4);
      end
    end
    @(negedge clk); out_ready4 = 1'b1;
    @(posedge clk); #1 out_ready4 = 1'b0;
    n_checks++;
    if ({in_ready4, out_valid4} !== 2'b10) begin
      n_fail++; $display("FAIL bp_release got ready=%b valid=%b exp 1/0", in_ready4, out_valid4);
    end
    @(posedge clk); #1 in_valid4 = 1'b0;
    n_checks++;
    if (busy4 !== 1'b1) begin
      n_fail++; $display("FAIL bp_accept got busy=%b exp 1", busy4);
    end
    k = 0;
    while (!out_valid4 && k < 100) begin @(posedge clk); #1 k++; end
    n_checks++;
    if (!out_valid4 || {result4, co4, ov4} !== {32'h2345_6789, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL bp_pending got %h/%b/%b valid=%b exp 23456789/0/0",
                         result4, co4, ov4, out_valid4);
    end
    release4();
  endtask

  task automatic test_reset_mid_run();
    int lat; logic to;
    @(negedge clk);
    op_a = 128'hFFFF_FFFF; op_b = 128'h0101_0101; carry_in = 0; sub = 0;
    in_valid4 = 1'b1;
    @(posedge clk); #1 in_valid4 = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({in_ready4, out_valid4, busy4, result4, co4, ov4} !== {3'b100, 34'd0}) begin
      n_fail++; $display("FAIL reset_mid_run got %b%b%b %h/%b/%b exp 100 00000000/0/0",
                         in_ready4, out_valid4, busy4, result4, co4, ov4);
    end
    @(negedge clk); rst = 1'b1;
    run4(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, lat, to);
    n_checks++;
    if (to || {result4, co4, ov4} !== {32'h0001_0000, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL after_reset got %h/%b/%b exp 00010000/0/0", result4, co4, ov4);
    end
    release4();
  endtask

  task automatic test_random();
    logic [127:0] a, b, er;
    logic cin, s, eco, eov;
    int k;
    for (int it = 0; it < 1000; it++) begin
      a   = {$urandom(), $urandom(), $urandom(), $urandom()};
      b   = {$urandom(), $urandom(), $urandom(), $urandom()};
      cin = 1'($urandom_range(0, 1));
      s   = 1'($urandom_range(0, 1));
      @(negedge clk);
      op_a = a; op_b = b; carry_in = cin; sub = s;
      in_valid4 = 1'b1; in_valid_x = 1'b1;
      @(posedge clk); #1 in_valid4 = 1'b0; in_valid_x = 1'b0;
      k = 0;
      while (!(out_valid4 && out_valid2 && out_valid16) && k < 40) begin
        @(posedge clk); #1 k++;
      end
      model(2, a, b, cin, s, er, eco, eov);
      n_checks++;
      if (!out_valid2 || {result2, co2, ov2} !== {er[15:0], eco, eov}) begin
        n_fail++; $display("FAIL rand2 it %0d got %h/%b/%b exp %h/%b/%b",
                           it, result2, co2, ov2, er[15:0], eco, eov);
      end
      model(4, a, b, cin, s, er, eco, eov);
      n_checks++;
      if (!out_valid4 || {result4, co4, ov4} !== {er[31:0], eco, eov}) begin
        n_fail++; $display("FAIL rand4 it %0d got %h/%b/%b exp %h/%b/%b",
                           it, result4, co4, ov4, er[31:0], eco, eov);
      end
      model(16, a, b, cin, s, er, eco, eov);
      n_checks++;
      if (!out_valid16 || {result16, co16, ov16} !== {er, eco, eov}) begin
        n_fail++; $display("FAIL rand16 it %0d got %h/%b/%b exp %h/%b/%b",
                           it, result16, co16, ov16, er, eco, eov);
      end
      @(negedge clk); out_ready4 = 1'b1; out_ready_x = 1'b1;
      @(posedge clk); #1 out_ready4 = 1'b0; out_ready_x = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_carry();
    test_sub();
    test_backpressure();
    test_reset_mid_run();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
